fm_s2p_gather: RTL

- Parametrised serial-to-parallel frame gatherer for the DDR/BRAM datapath: packs APP_DATA_WIDTH-bit beats into one wide frame of 1..MAX_SEQ_CNT beats.
- Frame length is selectable at run time; a flush input closes partial frames.
- Valid/ready handshakes on both sides with full backpressure.
- Double-buffered (assembly register + output register), so a new frame can be gathered while the previous one waits for the consumer.

---
 rtl/fm_s2p_gather.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fm_s2p_gather.sv
// fm_s2p_gather: packs narrow beats into one wide frame of 1..MAX_SEQ_CNT beats.
// Assembly register feeds a separate output register so gathering overlaps draining.
module fm_s2p_gather #(
  parameter int APP_DATA_WIDTH = 64,
  parameter int MAX_SEQ_CNT    = 8,
  parameter int CNT_W          = $clog2(MAX_SEQ_CNT + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CNT_W-1:0]                    seq_cnt,
  input  logic                                in_valid,
  input  logic [APP_DATA_WIDTH-1:0]           in_data,
  output logic                                in_ready,
  input  logic                                flush,
  output logic                                out_valid,
  output logic [APP_DATA_WIDTH*MAX_SEQ_CNT-1:0] out_data,
  output logic [CNT_W-1:0]                    out_cnt,
  output logic                                out_partial,
  input  logic                                out_ready
);

  localparam int W  = APP_DATA_WIDTH;
  localparam int FW = APP_DATA_WIDTH * MAX_SEQ_CNT;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [FW-1:0]    asm_q, asm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic             part_q, part_d;
  logic [FW-1:0]    out_data_q, out_data_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_partial_q, out_partial_d;
  logic             out_valid_q, out_valid_d;

  logic             acc;
  logic             xfer;
  logic             close;
  logic             close_part;
  logic [CNT_W-1:0] seq_tgt;
  logic [CNT_W-1:0] cur_tgt;
  logic [CNT_W-1:0] new_cnt;
  logic [FW-1:0]    frame;

  // Out-of-range lengths fall back to the widest frame
  always_comb begin
    seq_tgt = seq_cnt;
    if (seq_cnt == '0 || seq_cnt > CNT_W'(MAX_SEQ_CNT)) begin
      seq_tgt = CNT_W'(MAX_SEQ_CNT);
    end
  end

  always_comb begin
    state_d       = state_q;
    asm_d         = asm_q;
    cnt_d         = cnt_q;
    tgt_d         = tgt_q;
    part_d        = part_q;
    out_data_d    = out_data_q;
    out_cnt_d     = out_cnt_q;
    out_partial_d = out_partial_q;
    out_valid_d   = out_valid_q;
    close         = 1'b0;
    close_part    = 1'b0;

    acc     = in_valid && (state_q != HOLD);
    xfer    = out_valid_q && out_ready;
    cur_tgt = (state_q == IDLE) ? seq_tgt : tgt_q;
    new_cnt = cnt_q + {{(CNT_W-1){1'b0}}, acc};

    frame = asm_q;
    for (int i = 0; i < MAX_SEQ_CNT; i++) begin
      if (acc && cnt_q == CNT_W'(i)) begin
        frame[i*W +: W] = in_data;
      end
    end

    if (xfer) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: close = acc && ((seq_tgt == CNT_W'(1)) || flush);
      FILL: close = (acc && new_cnt == tgt_q) || flush;
      HOLD: begin
        if (xfer) begin
          out_valid_d   = 1'b1;
          out_data_d    = asm_q;
          out_cnt_d     = cnt_q;
          out_partial_d = part_q;
          asm_d         = '0;
          cnt_d         = '0;
          part_d        = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != HOLD) begin
      if (acc) begin
        asm_d = frame;
        cnt_d = new_cnt;
      end
      if (acc && state_q == IDLE) begin
        tgt_d   = seq_tgt;
        state_d = FILL;
      end
      if (close) begin
        close_part = new_cnt < cur_tgt;
        if (!out_valid_q || xfer) begin
          out_valid_d   = 1'b1;
          out_data_d    = frame;
          out_cnt_d     = new_cnt;
          out_partial_d = close_part;
          asm_d         = '0;
          cnt_d         = '0;
          state_d       = IDLE;
        end else begin
          asm_d   = frame;
          cnt_d   = new_cnt;
          part_d  = close_part;
          state_d = HOLD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      asm_q         <= '0;
      cnt_q         <= '0;
      tgt_q         <= '0;
      part_q        <= 1'b0;
      out_data_q    <= '0;
      out_cnt_q     <= '0;
      out_partial_q <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      asm_q         <= asm_d;
      cnt_q         <= cnt_d;
      tgt_q         <= tgt_d;
      part_q        <= part_d;
      out_data_q    <= out_data_d;
      out_cnt_q     <= out_cnt_d;
      out_partial_q <= out_partial_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign in_ready    = (state_q != HOLD);
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_cnt     = out_cnt_q;
  assign out_partial = out_partial_q;

endmodule
